intpol_run_seq: RTL and testbench
=================================

INTPOL_RUN_SEQ -- requirements
Module: intpol_run_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7: width of run length and sink length.
REQ-002 SHALL have parameter TO_WIDTH, default 16: width of watchdog timeout and watchdog counter.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start_i, input, 1: run request, sampled only in IDLE.
REQ-006 SHALL have port abort_i, input, 1: cancel the active run.
REQ-007 SHALL have port ilen_i, input, ADDR_WIDTH: run length, latched on accepted start.
REQ-008 SHALL have port timeout_i, input, TO_WIDTH: watchdog limit in cycles, latched on accepted start; 0 disables the watchdog.
REQ-009 SHALL have port src_done_i, input, 1: one-cycle completion pulse from the source block.
REQ-010 SHALL have port snk_done_i, input, 1: one-cycle completion pulse from the sink block.
REQ-011 SHALL have port snk_start_o, output, 1: one-cycle sink launch pulse.
REQ-012 SHALL have port src_start_o, output, 1: one-cycle source launch pulse.
REQ-013 SHALL have port snk_len_o, output, ADDR_WIDTH: latched run length, held stable from launch until the next accepted start.
REQ-014 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done_o, output, 1: one-cycle successful-completion pulse.
REQ-016 SHALL have port err_o, output, 1: one-cycle failure pulse.
REQ-017 SHALL have port err_code_o, output, 2: 00 none, 01 timeout, 10 abort; sticky until the next accepted start.
REQ-018 SHALL have port run_cnt_o, output, 8: count of successful runs.

Function
REQ-019 SHALL implement states IDLE, LAUNCH_SNK, LAUNCH_SRC, RUN, DONE and ERR.
REQ-020 IDLE: start_i=1 with ilen_i!=0 SHALL latch ilen_i and timeout_i, clear err_code_o, clear both done flags, and go to LAUNCH_SNK.
REQ-021 IDLE: start_i=1 with ilen_i=0 SHALL go directly to DONE without asserting either launch pulse.
REQ-022 LAUNCH_SNK SHALL assert snk_start_o for exactly one cycle, then go to LAUNCH_SRC.
REQ-023 LAUNCH_SRC SHALL assert src_start_o for exactly one cycle, then go to RUN.
REQ-024 Latency: with start_i sampled at cycle 0, snk_start_o SHALL assert in cycle 1, src_start_o in cycle 2, and RUN SHALL be entered in cycle 3.
REQ-025 From LAUNCH_SRC onward, each done pulse SHALL set its own sticky flag; pulses seen in IDLE or LAUNCH_SNK SHALL be ignored.
REQ-026 Done pulses MAY arrive in either order or in the same cycle; RUN SHALL go to DONE in the cycle after both flags are set (or set in that cycle).
REQ-027 DONE SHALL last one cycle, assert done_o, increment run_cnt_o modulo 256 (255 wraps to 0), then return to IDLE.
REQ-028 The watchdog counter SHALL clear on entry to RUN and increment each RUN cycle, saturating at its maximum value.
REQ-029 When timeout_l!=0 and counter==timeout_l, the block SHALL go to ERR with code 01.
REQ-030 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-031 abort_i in LAUNCH_SNK, LAUNCH_SRC or RUN SHALL go to ERR with code 10; abort SHALL take priority over completion and timeout.
REQ-032 abort_i in IDLE, DONE or ERR SHALL be ignored.
REQ-033 ERR SHALL last one cycle, assert err_o, leave run_cnt_o unchanged, then return to IDLE.
REQ-034 start_i while busy_o=1 SHALL be ignored, and the latched values SHALL not change.
REQ-035 done_o and err_o SHALL never assert in the same cycle.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 rstn=0 SHALL immediately force IDLE and set every output, flag, latched value and counter to 0.
REQ-038 Reset mid-run SHALL produce no done_o or err_o pulse; after release the block SHALL accept a new start_i on the first clock edge.

Verification
REQ-039 Nominal run: ilen_i=100, timeout_i=0, start at cycle 0, src_done at cycle 20, snk_done at cycle 120 -> snk_start_o at cycle 1, src_start_o at cycle 2, done_o at cycle 121, run_cnt_o=1, snk_len_o=100.
REQ-040 Simultaneous and reversed completion: snk_done and src_done in the same cycle -> done_o on the next cycle; snk_done before src_done -> done_o follows src_done by one cycle.
REQ-041 Timeout: timeout_i=5 with no done pulses -> err_o in cycle 9, err_code_o=01, run_cnt_o unchanged; timeout coinciding with the second done pulse -> done_o, not err_o.
REQ-042 Abort: abort_i in cycle 4 of RUN, together with both done pulses -> err_o next cycle, err_code_o=10; a following start clears err_code_o to 00.
REQ-043 Zero length and reset: ilen_i=0 -> done_o in cycle 1 with no launch pulses; rstn low mid-RUN -> all outputs 0 and no pulses; 256 runs -> run_cnt_o wraps to 0.

Source files
------------

// File: rtl/intpol_run_seq.sv
// Run sequencer: launches the sink and then the source, waits for both completion pulses,
// and reports done, timeout or abort through registered status outputs.
module intpol_run_seq #(
   parameter int ADDR_WIDTH = 7,
   parameter int TO_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [ADDR_WIDTH-1:0] ilen_i,
   input  logic [TO_WIDTH-1:0]   timeout_i,
   input  logic                  src_done_i,
   input  logic                  snk_done_i,
   output logic                  snk_start_o,
   output logic                  src_start_o,
   output logic [ADDR_WIDTH-1:0] snk_len_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [1:0]            err_code_o,
   output logic [7:0]            run_cnt_o
);

   typedef enum logic [2:0] {
      IDLE, LAUNCH_SNK, LAUNCH_SRC, RUN, DONE, ERR
   } state_t;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_TIMEOUT = 2'b01;
   localparam logic [1:0] CODE_ABORT   = 2'b10;

   state_t              state, nxt;
   logic [TO_WIDTH-1:0] timeout_l, wd_cnt;
   logic                src_flg, snk_flg;
   logic                src_seen, snk_seen, fin, tmo, accept;
   logic [1:0]          code_nxt;

   always_comb begin
      nxt      = state;
      accept   = 1'b0;
      code_nxt = err_code_o;
      src_seen = src_flg | src_done_i;
      snk_seen = snk_flg | snk_done_i;
      fin      = src_seen & snk_seen;
      tmo      = (timeout_l != '0) && (wd_cnt == timeout_l);
      case (state)
         IDLE: begin
            if (start_i) begin
               accept   = 1'b1;
               code_nxt = CODE_NONE;
               nxt      = (ilen_i == '0) ? DONE : LAUNCH_SNK;
            end
         end
         LAUNCH_SNK, LAUNCH_SRC: begin
            if (abort_i) begin
               nxt      = ERR;
               code_nxt = CODE_ABORT;
            end else begin
               nxt = (state == LAUNCH_SNK) ? LAUNCH_SRC : RUN;
            end
         end
         RUN: begin
            // abort beats completion, completion beats the watchdog
            if (abort_i) begin
               nxt      = ERR;
               code_nxt = CODE_ABORT;
            end else if (fin) begin
               nxt = DONE;
            end else if (tmo) begin
               nxt      = ERR;
               code_nxt = CODE_TIMEOUT;
            end
         end
         DONE, ERR: nxt = IDLE;
         default:   nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= nxt;
   end

   // Outputs are decoded from the next state so they are registered yet cycle-aligned with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         snk_start_o <= 1'b0;
         src_start_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         err_code_o  <= CODE_NONE;
         run_cnt_o   <= '0;
         snk_len_o   <= '0;
         timeout_l   <= '0;
         src_flg     <= 1'b0;
         snk_flg     <= 1'b0;
         wd_cnt      <= '0;
      end else begin
         snk_start_o <= (nxt == LAUNCH_SNK);
         src_start_o <= (nxt == LAUNCH_SRC);
         busy_o      <= (nxt != IDLE);
         done_o      <= (nxt == DONE);
         err_o       <= (nxt == ERR);
         err_code_o  <= code_nxt;
         if (nxt == DONE) run_cnt_o <= run_cnt_o + 8'd1;
         if (accept) begin
            snk_len_o <= ilen_i;
            timeout_l <= timeout_i;
            src_flg   <= 1'b0;
            snk_flg   <= 1'b0;
         end else if (state == LAUNCH_SRC || state == RUN) begin
            src_flg <= src_seen;
            snk_flg <= snk_seen;
         end
         if (state != RUN)         wd_cnt <= '0;
         else if (wd_cnt != '1)    wd_cnt <= wd_cnt + TO_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_intpol_run_seq.sv
// Randomized and directed bench for intpol_run_seq against a run-relative behavioural model.
module tb_intpol_run_seq;

   localparam int AW = 7;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start_i = 1'b0, abort_i = 1'b0, src_done_i = 1'b0, snk_done_i = 1'b0;
   logic [AW-1:0] ilen_i = '0;
   logic [TW-1:0] timeout_i = '0;
   logic          snk_start_o, src_start_o, busy_o, done_o, err_o;
   logic [AW-1:0] snk_len_o;
   logic [1:0]    err_code_o;
   logic [7:0]    run_cnt_o;

   intpol_run_seq #(.ADDR_WIDTH(AW), .TO_WIDTH(TW)) dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .abort_i(abort_i), .ilen_i(ilen_i),
      .timeout_i(timeout_i), .src_done_i(src_done_i), .snk_done_i(snk_done_i),
      .snk_start_o(snk_start_o), .src_start_o(src_start_o), .snk_len_o(snk_len_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
      .run_cnt_o(run_cnt_o)
   );

   always #5 clk = ~clk;

   // Model: k counts cycles since the accepted start (1 = sink launch, 2 = source launch, 3+ = running).
   typedef struct packed {
      logic          snk, src, busy, done, err;
      logic [1:0]    code;
      logic [7:0]    cnt;
      logic [AW-1:0] len;
      logic          run, fin, gs, gk;
      int            k;
      int            tl;
   } mdl_t;

   mdl_t m = '0;

   function automatic mdl_t step(input mdl_t c);
      mdl_t n = c;
      n.snk = 0; n.src = 0; n.done = 0; n.err = 0;
      if (c.fin) begin
         n.fin = 0;
      end else if (!c.run) begin
         if (start_i) begin
            n.code = 0; n.len = ilen_i; n.tl = int'(timeout_i); n.gs = 0; n.gk = 0;
            if (ilen_i == 0) begin
               n.done = 1; n.cnt = c.cnt + 8'd1; n.fin = 1;
            end else begin
               n.run = 1; n.k = 1; n.snk = 1;
            end
         end
      end else begin
         if (c.k >= 2) begin
            n.gs = c.gs | src_done_i;
            n.gk = c.gk | snk_done_i;
         end
         if (abort_i) begin
            n.err = 1; n.code = 2'b10; n.run = 0; n.fin = 1;
         end else if (c.k >= 3 && n.gs && n.gk) begin
            n.done = 1; n.cnt = c.cnt + 8'd1; n.run = 0; n.fin = 1;
         end else if (c.k >= 3 && c.tl != 0 && c.k - 3 == c.tl) begin
            n.err = 1; n.code = 2'b01; n.run = 0; n.fin = 1;
         end else begin
            n.k = c.k + 1;
            n.src = (n.k == 2);
         end
      end
      n.busy = n.run | n.fin;
      return n;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) m <= '0;
      else       m <= step(m);
   end

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Literal expectation: pins both the DUT and the model to a hand-computed value.
   task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                      input logic [31:0] v);
      chk(name, dut_v, v);
      chk({name, "_model"}, mdl_v, v);
   endtask

   always @(negedge clk) begin
      chk("snk_start", 32'(snk_start_o), 32'(m.snk));
      chk("src_start", 32'(src_start_o), 32'(m.src));
      chk("busy",      32'(busy_o),      32'(m.busy));
      chk("done",      32'(done_o),      32'(m.done));
      chk("err",       32'(err_o),       32'(m.err));
      chk("err_code",  32'(err_code_o),  32'(m.code));
      chk("run_cnt",   32'(run_cnt_o),   32'(m.cnt));
      chk("snk_len",   32'(snk_len_o),   32'(m.len));
   end

   int cur = 0;

   task automatic advance_to(input int c);
      while (cur < c) begin
         @(posedge clk); #1;
         cur++;
         start_i = 0; src_done_i = 0; snk_done_i = 0; abort_i = 0;
      end
   endtask

   task automatic start_run(input int len, input int to);
      start_i = 1; ilen_i = AW'(len); timeout_i = TW'(to); cur = 0;
   endtask

   initial begin
      #12;
      lit("rst_busy", 32'(busy_o), 32'(m.busy), 0);
      lit("rst_cnt", 32'(run_cnt_o), 32'(m.cnt), 0);
      @(posedge clk); #1; rstn = 1;

      // nominal run
      start_run(100, 0);
      advance_to(1);  lit("nom_snk_start", 32'(snk_start_o), 32'(m.snk), 1);
      advance_to(2);  lit("nom_src_start", 32'(src_start_o), 32'(m.src), 1);
      advance_to(20); src_done_i = 1;
      advance_to(120); snk_done_i = 1;
      advance_to(121);
      lit("nom_done", 32'(done_o), 32'(m.done), 1);
      lit("nom_cnt", 32'(run_cnt_o), 32'(m.cnt), 1);
      lit("nom_len", 32'(snk_len_o), 32'(m.len), 100);
      advance_to(122);

      // simultaneous completion
      start_run(9, 0);
      advance_to(10); src_done_i = 1; snk_done_i = 1;
      advance_to(11); lit("sim_done", 32'(done_o), 32'(m.done), 1);
      advance_to(12);

      // reversed completion
      start_run(9, 0);
      advance_to(8); snk_done_i = 1;
      advance_to(15); src_done_i = 1;
      advance_to(16); lit("rev_done", 32'(done_o), 32'(m.done), 1);
      lit("rev_cnt", 32'(run_cnt_o), 32'(m.cnt), 3);
      advance_to(17);

      // watchdog timeout
      start_run(9, 5);
      advance_to(8); lit("to_quiet", 32'(err_o), 32'(m.err), 0);
      advance_to(9);
      lit("to_err", 32'(err_o), 32'(m.err), 1);
      lit("to_code", 32'(err_code_o), 32'(m.code), 1);
      lit("to_cnt", 32'(run_cnt_o), 32'(m.cnt), 3);
      advance_to(10);

      // timeout coinciding with second done: completion wins
      start_run(9, 5);
      advance_to(4); src_done_i = 1;
      advance_to(8); snk_done_i = 1;
      advance_to(9);
      lit("tie_done", 32'(done_o), 32'(m.done), 1);
      lit("tie_err", 32'(err_o), 32'(m.err), 0);
      advance_to(10);

      // abort together with both done pulses
      start_run(9, 0);
      advance_to(6); abort_i = 1; src_done_i = 1; snk_done_i = 1;
      advance_to(7);
      lit("ab_err", 32'(err_o), 32'(m.err), 1);
      lit("ab_code", 32'(err_code_o), 32'(m.code), 2);
      lit("ab_cnt", 32'(run_cnt_o), 32'(m.cnt), 4);
      advance_to(8);
      start_run(5, 0);
      advance_to(1); lit("ab_clear", 32'(err_code_o), 32'(m.code), 0);
      advance_to(2); abort_i = 1;
      advance_to(3); lit("ab_launch", 32'(err_code_o), 32'(m.code), 2);
      advance_to(4);

      // zero length
      start_run(0, 0);
      advance_to(1);
      lit("zl_done", 32'(done_o), 32'(m.done), 1);
      lit("zl_nolaunch", 32'(snk_start_o), 32'(m.snk), 0);
      lit("zl_cnt", 32'(run_cnt_o), 32'(m.cnt), 5);
      advance_to(2);

      // reset mid-run, then start on the first edge after release
      start_run(20, 0);
      advance_to(5);
      rstn = 0; #1;
      lit("rr_busy", 32'(busy_o), 32'(m.busy), 0);
      lit("rr_cnt", 32'(run_cnt_o), 32'(m.cnt), 0);
      lit("rr_len", 32'(snk_len_o), 32'(m.len), 0);
      @(posedge clk); #1;
      rstn = 1;
      start_run(3, 0);
      advance_to(1); lit("rr_restart", 32'(snk_start_o), 32'(m.snk), 1);
      advance_to(2); abort_i = 1;
      advance_to(4);

      // 256 runs wrap the counter
      rstn = 0; @(posedge clk); #1; rstn = 1;
      for (int r = 1; r <= 256; r++) begin
         start_run(0, 0);
         advance_to(2);
         if (r == 255) lit("wrap_255", 32'(run_cnt_o), 32'(m.cnt), 255);
      end
      lit("wrap_0", 32'(run_cnt_o), 32'(m.cnt), 0);

      // randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         rstn       = (i != 2000);
         start_i    = ($urandom_range(0, 99) < 30);
         ilen_i     = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom);
         timeout_i  = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 25));
         src_done_i = ($urandom_range(0, 99) < 12);
         snk_done_i = ($urandom_range(0, 99) < 12);
         abort_i    = ($urandom_range(0, 99) < 3);
      end
      @(posedge clk); #1;
      rstn = 1; start_i = 0; src_done_i = 0; snk_done_i = 0; abort_i = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
